// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the program store it fills.
package imem_loader_pkg;

    localparam int IMEM_DEPTH     = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_ready marks the handshake
// of the last lane, so the word register is complete on the following cycle.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [LANE_W-1:0] byte_idx_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx_reg <= '0;
        end else if (take) begin
            byte_idx_reg <= byte_idx_reg + LANE_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    lane_reg <= '0;
                end else if (take && (byte_idx_reg == LANE_W'(gi))) begin
                    lane_reg <= data;
                end
            end

            assign word[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    assign word_ready = take && (byte_idx_reg == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction memory from a byte stream while holding the core in reset;
// pulses done and releases the core once the requested number of words is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    loader_state_t    state_reg, state_next;
    logic [CNT_W-1:0] word_idx_reg;
    logic [CNT_W-1:0] num_words_reg;
    logic [31:0]      packed_word;
    logic             word_ready;
    logic             count_ok;
    logic             accept_start;
    logic             last_word;
    logic             take;

    assign count_ok     = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
    assign accept_start = (state_reg == IDLE) && start && count_ok;
    assign last_word    = (word_idx_reg == num_words_reg - CNT_W'(1));
    assign take         = s_valid && s_ready;

    imem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept_start),
        .take       (take),
        .data       (s_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            word_idx_reg  <= '0;
            num_words_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept_start) begin
                num_words_reg <= num_words;
                word_idx_reg  <= '0;
            end else if ((state_reg == WRITE) && !last_word) begin
                word_idx_reg <= word_idx_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_start) state_next = LOAD;
            LOAD:    if (word_ready) state_next = WRITE;
            WRITE:   state_next = last_word ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pulses and the handshake are masked while reset is asserted so a reset
    // cycle never consumes a byte or commits a write.
    always_comb begin
        s_ready   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        error     = 1'b0;
        busy      = (state_reg != IDLE);
        cpu_hold  = (state_reg != IDLE);
        case (state_reg)
            IDLE:  error = start && !count_ok && !reset;
            LOAD:  s_ready = !reset;
            WRITE: begin
                mem_we    = !reset;
                mem_addr  = {{(32-CNT_W-2){1'b0}}, word_idx_reg, 2'b00};
                mem_wdata = packed_word;
            end
            DONE:  done = !reset;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle-exact vector table plus streamed load sequences.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int CNT_W = $clog2(IMEM_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic             s_valid = 1'b0;
    logic [7:0]       s_data = '0;
    logic             s_ready, mem_we, cpu_hold, busy, done, error;
    logic [31:0]      mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_q[$];

    imem_loader #(.DEPTH(IMEM_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Write/done monitor, sampled mid-cycle after the driver settles.
    always @(negedge clk) begin
        #2;
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            $display("write addr=%h data=%h", mem_addr, mem_wdata);
            checks++;
            if (s_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_ready: s_ready=%0b in write cycle, required 0", s_ready);
            end
        end
        if (done) done_cnt++;
    end

    typedef struct {
        logic             start;
        logic [CNT_W-1:0] nw;
        logic             sv;
        logic [7:0]       sd;
        logic [5:0]       flags;  // {s_ready, mem_we, cpu_hold, busy, done, error}
        logic [31:0]      addr;
        logic [31:0]      wdata;
    } vec_t;

    vec_t tv[17];

    function automatic vec_t mk(input logic st, input int nw, input logic sv, input logic [7:0] sd,
                                input logic [5:0] flags, input logic [31:0] addr, input logic [31:0] wdata);
        vec_t v;
        v.start = st; v.nw = CNT_W'(nw); v.sv = sv; v.sd = sd;
        v.flags = flags; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic st, input int st_nw);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = b; start = st;
        if (st) num_words = CNT_W'(st_nw);
        #1;
        while (!s_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles, required acceptance", b, n);
        end
        @(posedge clk);
    endtask

    task automatic load_words(input int n, input bit gaps, input int restart_at);
        int d0;
        bit found;
        logic [31:0] wd;
        int m;
        wr_addr_q.delete();
        wr_data_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; num_words = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < n; w++) begin
            wd = exp_q[w];
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(negedge clk);
                        s_valid = 1'b0;
                    end
                end
                send_byte(wd[8*b +: 8], (w == restart_at) && (b == 0), 3);
            end
        end
        @(negedge clk);
        s_valid = 1'b0; start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (done) found = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", 32'(found), 32'd1);
        @(negedge clk);
        #1;
        chk("hold_after_done", 32'(cpu_hold), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk("write_count", 32'(wr_addr_q.size()), 32'(n));
        m = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("write_addr[%0d]", i), wr_addr_q[i], 32'(i) << 2);
            chk($sformatf("write_data[%0d]", i), wr_data_q[i], exp_q[i]);
        end
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] act;
        // start/nw/sv/sd | {rdy,we,hold,busy,done,err} | addr | wdata
        tv[0]  = mk(1, 2,  0, 8'h00, 6'b000000, 32'h0, 32'h0);
        tv[1]  = mk(0, 0,  1, 8'h13, 6'b101100, 32'h0, 32'h0);
        tv[2]  = mk(0, 0,  1, 8'h00, 6'b101100, 32'h0, 32'h0);
        tv[3]  = mk(0, 0,  1, 8'h00, 6'b101100, 32'h0, 32'h0);
        tv[4]  = mk(0, 0,  1, 8'h00, 6'b101100, 32'h0, 32'h0);
        tv[5]  = mk(0, 0,  1, 8'hB3, 6'b011100, 32'h0, 32'h00000013);
        tv[6]  = mk(0, 0,  1, 8'hB3, 6'b101100, 32'h0, 32'h0);
        tv[7]  = mk(1, 5,  1, 8'h82, 6'b101100, 32'h0, 32'h0);
        tv[8]  = mk(0, 0,  1, 8'h41, 6'b101100, 32'h0, 32'h0);
        tv[9]  = mk(0, 0,  1, 8'h00, 6'b101100, 32'h0, 32'h0);
        tv[10] = mk(0, 0,  0, 8'h00, 6'b011100, 32'h4, 32'h004182B3);
        tv[11] = mk(0, 0,  0, 8'h00, 6'b001110, 32'h0, 32'h0);
        tv[12] = mk(0, 0,  0, 8'h00, 6'b000000, 32'h0, 32'h0);
        tv[13] = mk(1, 0,  0, 8'h00, 6'b000001, 32'h0, 32'h0);
        tv[14] = mk(0, 0,  0, 8'h00, 6'b000000, 32'h0, 32'h0);
        tv[15] = mk(1, 33, 0, 8'h00, 6'b000001, 32'h0, 32'h0);
        tv[16] = mk(0, 0,  0, 8'h00, 6'b000000, 32'h0, 32'h0);

        // Reset held three cycles with a byte on offer.
        s_valid = 1'b1; s_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            act = {s_ready, mem_we, cpu_hold, busy, done, error};
            $display("reset cycle %0d flags=%b", i, act);
            chk($sformatf("reset_flags[%0d]", i), 32'(act), 32'd0);
            chk($sformatf("reset_addr_data[%0d]", i), mem_addr | mem_wdata, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0; s_valid = 1'b0; s_data = '0;

        // Cycle-exact table: two-word load (incl. byte held in WRITE and start while busy), illegal counts.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            start = tv[i].start; num_words = tv[i].nw; s_valid = tv[i].sv; s_data = tv[i].sd;
            #1;
            act = {s_ready, mem_we, cpu_hold, busy, done, error};
            checks++;
            if (act !== tv[i].flags || mem_addr !== tv[i].addr || mem_wdata !== tv[i].wdata) begin
                errors++;
                $display("FAIL vec[%0d]: got flags=%b addr=%h data=%h, required flags=%b addr=%h data=%h",
                         i, act, mem_addr, mem_wdata, tv[i].flags, tv[i].addr, tv[i].wdata);
            end else begin
                $display("vec[%0d] flags=%b addr=%h data=%h", i, act, mem_addr, mem_wdata);
            end
        end
        @(negedge clk);
        start = 1'b0; s_valid = 1'b0;

        // Same two words with random valid gaps.
        exp_q = '{32'h00000013, 32'h004182B3};
        load_words(2, 1'b1, -1);

        // Reset after two bytes of word 0, then reload one word.
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        start = 1'b1; num_words = CNT_W'(1);
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b1; s_data = 8'hCC;
        #1;
        chk("rst_cycle_we", 32'(mem_we), 32'd0);
        chk("rst_cycle_ready", 32'(s_ready), 32'd0);
        chk("rst_cycle_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_next_hold", 32'(cpu_hold), 32'd0);
        chk("rst_next_busy", 32'(busy), 32'd0);
        reset = 1'b0; s_valid = 1'b0;
        chk("rst_no_write", 32'(wr_addr_q.size()), 32'd0);
        exp_q = '{32'hDEADBEEF};
        load_words(1, 1'b0, -1);

        // Full depth with a stray start (num_words=3) during word 10.
        exp_q.delete();
        for (int i = 0; i < IMEM_DEPTH; i++) exp_q.push_back(32'h10000000 + 32'(i));
        load_words(IMEM_DEPTH, 1'b0, 10);
        if (wr_addr_q.size() == IMEM_DEPTH)
            chk("last_addr", wr_addr_q[IMEM_DEPTH-1], 32'h7C);
        else
            chk("last_addr_count", 32'(wr_addr_q.size()), 32'(IMEM_DEPTH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
